// File: rtl/ub_stream_pkg.sv
// Shared types and constants for the unified-buffer streamer.
package ub_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  // Default width of one lane slice (one signed activation).
  localparam int LANE_W = 7;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ub_stream_if.sv
// Valid/ready stream of packed activation rows.
interface ub_stream_if
  import ub_stream_pkg::*;
#(
  parameter int SIZE             = 8,
  parameter int ACTIVATION_WIDTH = LANE_W
);
  logic                             out_valid;
  logic                             out_ready;
  logic [SIZE*ACTIVATION_WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/ub_skew_line.sv
// Per-lane beat delay (lane j lags j beats); shifts only on advance, zero-filled on clear.
module ub_skew_line #(
  parameter int SIZE = 8,
  parameter int AW   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [SIZE*AW-1:0]   in_row,
  output logic [SIZE*AW-1:0]   out_row
);

  assign out_row[AW-1:0] = in_row[AW-1:0];

  genvar gi;
  generate
    for (gi = 1; gi < SIZE; gi++) begin : g_lane
      logic [AW-1:0] chain_reg [0:gi-1];

      // Stage s holds this lane of the row fetched s+1 advances ago.
      assign out_row[gi*AW +: AW] = clear ? '0 : chain_reg[gi-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < gi; s++) chain_reg[s] <= '0;
        end else if (advance) begin
          chain_reg[0] <= in_row[gi*AW +: AW];
          for (int s = 1; s < gi; s++) chain_reg[s] <= clear ? '0 : chain_reg[s-1];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ub_stream.sv
// Unified buffer: masked multi-lane row writes, single-element reads, and a
// row streamer with optional diagonal skew for systolic-array feeding.
module ub_stream
  import ub_stream_pkg::*;
#(
  parameter int SIZE             = 8,
  parameter int ACTIVATION_WIDTH = LANE_W,
  parameter int DEPTH            = 64,
  localparam int ADDR_W          = addr_w(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [SIZE-1:0]                  wr_mask,
  input  logic [SIZE*ACTIVATION_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [ACTIVATION_WIDTH-1:0]      rd_data,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_addr,
  input  logic [ADDR_W:0]                  row_count,
  input  logic                             skew_en,
  output logic                             busy,
  output logic                             done,
  ub_stream_if.master                      out
);

  localparam int AW    = ACTIVATION_WIDTH;
  localparam int CNT_W = ADDR_W + 2;

  logic [AW-1:0]      mem [0:DEPTH-1];
  logic [AW-1:0]      rd_data_reg;

  state_t             state_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               valid_reg;
  logic [SIZE*AW-1:0] data_reg;
  logic [ADDR_W-1:0]  ptr_reg;
  logic [CNT_W-1:0]   beat_reg;
  logic [ADDR_W:0]    rows_reg;
  logic               skew_reg;

  logic [ADDR_W-1:0]  fetch_addr;
  logic [CNT_W-1:0]   fetch_idx;
  logic [CNT_W-1:0]   rows_sel;
  logic               skew_sel;
  logic [SIZE*AW-1:0] fetch_row;
  logic [SIZE*AW-1:0] row_gated;
  logic [SIZE*AW-1:0] skew_row;
  logic [SIZE*AW-1:0] beat_next;
  logic [CNT_W-1:0]   last_idx;
  logic               is_last;
  logic               accept;
  logic               handshake;
  logic               load_en;

  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (wr_en && wr_mask[i]) mem[wr_addr + ADDR_W'(i)] <= wr_data[i*AW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_reg <= '0;
    else     rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

  // In IDLE the fetch targets row 0 of the request being accepted.
  assign fetch_addr = (state_reg == S_IDLE) ? base_addr : ptr_reg + ADDR_W'(SIZE);
  assign fetch_idx  = (state_reg == S_IDLE) ? '0 : beat_reg + CNT_W'(1);
  assign rows_sel   = (state_reg == S_IDLE) ? CNT_W'(row_count) : CNT_W'(rows_reg);
  assign skew_sel   = (state_reg == S_IDLE) ? skew_en : skew_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_fetch
      assign fetch_row[gi*AW +: AW] = mem[fetch_addr + ADDR_W'(gi)];
    end
  endgenerate

  // Past the last real row the skew tail drains zeros.
  assign row_gated = (fetch_idx < rows_sel) ? fetch_row : '0;
  assign beat_next = skew_sel ? skew_row : row_gated;

  assign last_idx  = skew_reg ? CNT_W'(rows_reg) + CNT_W'(SIZE - 1) - CNT_W'(1)
                              : CNT_W'(rows_reg) - CNT_W'(1);
  assign is_last   = (beat_reg == last_idx);
  assign accept    = (state_reg == S_IDLE) && start;
  assign handshake = (state_reg == S_STREAM) && valid_reg && out.out_ready;
  assign load_en   = (accept && (row_count != '0)) || (handshake && !is_last);

  ub_skew_line #(
    .SIZE (SIZE),
    .AW   (AW)
  ) u_skew (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_reg == S_IDLE),
    .advance (load_en),
    .in_row  (row_gated),
    .out_row (skew_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ptr_reg   <= '0;
      beat_reg  <= '0;
      rows_reg  <= '0;
      skew_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            rows_reg <= row_count;
            skew_reg <= skew_en;
            ptr_reg  <= base_addr;
            beat_reg <= '0;
            if (row_count != '0) begin
              state_reg <= S_STREAM;
              busy_reg  <= 1'b1;
              valid_reg <= 1'b1;
              data_reg  <= beat_next;
            end else begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (handshake) begin
            if (is_last) begin
              state_reg <= S_DONE;
              busy_reg  <= 1'b0;
              valid_reg <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              data_reg <= beat_next;
              ptr_reg  <= fetch_addr;
              beat_reg <= fetch_idx;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign out.out_valid = valid_reg;
  assign out.out_data  = data_reg;

endmodule

// File: doc/ub_stream.md
UB_STREAM -- requirements
Module: ub_stream

Interface
REQ-001 Parameter SIZE, default 8: lanes per row, equal to the systolic array width.
REQ-002 Parameter ACTIVATION_WIDTH, default 7: bits per element, signed.
REQ-003 Parameter DEPTH, default 64: element entries, power of two; ADDR_W = clog2(DEPTH).
REQ-004 Port clk, input, 1: single clock, all logic on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port wr_en, input, 1: row write strobe.
REQ-007 Port wr_addr, input, ADDR_W: element address of lane 0.
REQ-008 Port wr_mask, input, SIZE: per-lane write enable; bit i gates lane i.
REQ-009 Port wr_data, input, SIZE*ACTIVATION_WIDTH: lane i in bits [i*AW +: AW].
REQ-010 Port rd_addr, input, ADDR_W: single-element read address.
REQ-011 Port rd_data, output, ACTIVATION_WIDTH: registered single-element read data.
REQ-012 Port start, input, 1: stream request pulse.
REQ-013 Port base_addr, input, ADDR_W: element address of stream row 0, lane 0.
REQ-014 Port row_count, input, ADDR_W+1: rows to stream.
REQ-015 Port skew_en, input, 1: diagonal skew enable for systolic feed.
REQ-016 Port out_valid, output, 1: out_data holds a beat.
REQ-017 Port out_ready, input, 1: consumer accepts the beat.
REQ-018 Port out_data, output, SIZE*ACTIVATION_WIDTH: stream beat, lane packing as wr_data.
REQ-019 Port busy, output, 1: high in STREAM.
REQ-020 Port done, output, 1: one-cycle pulse at stream end.

Function
REQ-021 Write: when wr_en and wr_mask[i] are high, entry (wr_addr+i) mod DEPTH SHALL take lane i at the clock edge; unmasked entries SHALL hold.
REQ-022 Wrap-around: write and stream addresses SHALL wrap modulo DEPTH, with no error flag.
REQ-023 rd_data SHALL equal entry[rd_addr] one cycle after rd_addr is presented.
REQ-024 Read-before-write: a read or stream fetch of an entry written in the same cycle SHALL return the old value.
REQ-025 FSM states SHALL be IDLE, STREAM and DONE.
REQ-026 IDLE -> STREAM on start with row_count != 0.
REQ-027 IDLE -> DONE on start with row_count == 0; no beat SHALL be emitted.
REQ-028 STREAM -> DONE on handshake of the last beat.
REQ-029 DONE -> IDLE after one cycle; done SHALL be high only in DONE.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 base_addr, row_count and skew_en SHALL be latched at start acceptance.
REQ-032 Beat count SHALL be row_count with skew_en=0 and row_count+SIZE-1 with skew_en=1.
REQ-033 Unskewed: beat k lane j SHALL equal entry[(base + k*SIZE + j) mod DEPTH].
REQ-034 Skewed: beat k lane j SHALL equal row (k-j) lane j when 0 <= k-j < row_count, and 0 otherwise.
REQ-035 out_valid SHALL rise the cycle after start acceptance and stay high through the last beat.
REQ-036 A beat SHALL advance only on out_valid && out_ready.
REQ-037 While out_valid && !out_ready, out_data SHALL be held stable.
REQ-038 Zero-bubble rule: with out_ready held high, one beat SHALL issue per cycle.
REQ-039 Writes during STREAM SHALL be allowed; a beat SHALL reflect memory contents at its fetch cycle.

Reset
REQ-040 On rst, the FSM SHALL enter IDLE and busy, done, out_valid, out_data and rd_data SHALL be 0.
REQ-041 Reset mid-stream SHALL abort the stream without a done pulse.
REQ-042 Memory contents SHALL NOT be reset.

Structure
REQ-043 A shared package SHALL hold the FSM state enum, the ADDR_W derivation and the lane slice width constant.
REQ-044 One sub-module, ub_skew_line, SHALL implement the per-lane delay (lane j delayed j beats), stall-aware and zero-filled.

Verification
REQ-045 Write all lanes at addr 0 with data 1..8, then rd_addr=5 -> rd_data=6 one cycle later.
REQ-046 Write at addr 60 with data 1..8 -> entries 60..63 = 1..4 and entries 0..3 = 5..8.
REQ-047 Write with mask 8'b0000_0101 at addr 8 with all lanes 7 -> entries 8 and 10 = 7, all others unchanged.
REQ-048 Stream base 0, rows 2, skew off, out_ready toggling 1,0,1 -> 2 beats with rows 0 and 1 held during the stall, then done.
REQ-049 Stream rows 1 with skew on -> 8 beats; beat k has only lane k nonzero, equal to entry k.
REQ-050 Assert rst in beat 3 of 5 -> out_valid=0 next cycle, no done pulse; start then accepted normally.
